// File: rtl/riot_pkg.sv
// riot_pkg: shared types and constants for the riot_gen RAM/I/O/timer block.
// Holds register decode bit positions, prescale codes and flag bit positions.
package riot_pkg;

  localparam int RB_A0 = 0;
  localparam int RB_A1 = 1;
  localparam int RB_A2 = 2;
  localparam int RB_A3 = 3;
  localparam int RB_A4 = 4;

  localparam logic [1:0] OFS_DRA  = 2'd0;
  localparam logic [1:0] OFS_DDRA = 2'd1;
  localparam logic [1:0] OFS_DRB  = 2'd2;
  localparam logic [1:0] OFS_DDRB = 2'd3;

  localparam int FLG_T = 7;
  localparam int FLG_P = 6;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    PS1    = 2'd0,
    PS8    = 2'd1,
    PS64   = 2'd2,
    PS1024 = 2'd3
  } ps_e;

  function automatic logic [PC_W-1:0] ps_reload(
    input ps_e ps
  );
    logic [PC_W-1:0] r;
    r = '0;
    unique case (ps)
      PS1:    r = 10'd0;
      PS8:    r = 10'd7;
      PS64:   r = 10'd63;
      PS1024: r = 10'd1023;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riot_timer.sv
// riot_timer: 6532-style interval timer with prescaler and post-underflow
// fast count; owns TFLAG, cleared by load or by a timer read strobe.
module riot_timer
  import riot_pkg::*;
#(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               load,
  input  logic [7:0]         load_val,
  input  ps_e                load_ps,
  input  logic               rd_clr,
  output logic [TIMER_W-1:0] count,
  output logic               tflag
);

  ps_e             ps;
  logic [PC_W-1:0] pc;
  logic            fast;
  logic            tick;
  logic            uf;

  assign tick = ce & (pc == '0);
  assign uf   = tick & (count == '0);

  // once underflowed the prescaler stays parked at zero until reloaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '1;
      ps    <= PS1024;
      pc    <= ps_reload(PS1024);
      fast  <= 1'b0;
      tflag <= 1'b0;
    end else if (load) begin
      count <= TIMER_W'(load_val);
      ps    <= load_ps;
      pc    <= ps_reload(load_ps);
      fast  <= 1'b0;
      tflag <= 1'b0;
    end else begin
      if (tick) begin
        count <= count - TIMER_W'(1);
        pc    <= (fast | uf) ? '0 : ps_reload(ps);
        if (uf)
          fast <= 1'b1;
      end else if (ce) begin
        pc <= pc - PC_W'(1);
      end
      if (uf)
        tflag <= 1'b1;
      else if (rd_clr)
        tflag <= 1'b0;
    end
  end

endmodule

// File: rtl/riot_gen.sv
// riot_gen: 6532-class RAM, two I/O ports, interval timer and port A
// edge interrupt on the 65xx bus, qualified by the phi2 clock-enable.
module riot_gen
  import riot_pkg::*;
#(
  parameter int RAM_AW      = 7,
  parameter int PORT_W      = 8,
  parameter int EDGE_BIT    = 7,
  parameter int TIMER_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              cs,
  input  logic              rw,
  input  logic              rs,
  input  logic [RAM_AW-1:0] addr,
  input  logic [7:0]        dataIn,
  output logic [7:0]        dataOut,
  input  logic [PORT_W-1:0] paIn,
  output logic [PORT_W-1:0] paOut,
  output logic [PORT_W-1:0] paDdr,
  input  logic [PORT_W-1:0] pbIn,
  output logic [PORT_W-1:0] pbOut,
  output logic [PORT_W-1:0] pbDdr,
  output logic              irq
);

  logic [7:0] mem [2**RAM_AW];

  logic acc, rd, wr;
  logic ram_sel, io_sel, tmr_sel, flg_sel;
  logic ram_wr, io_wr, edg_wr, tmr_ld, tmr_rd, flg_rd;

  logic [PORT_W-1:0]  pa_pin, pb_pin;
  logic [7:0]         rdata;
  logic [TIMER_W-1:0] tcount;
  logic               tflag;
  logic               tie, pie, pol, pflag;
  logic [SYNC_STAGES:0] sh;
  logic               edge_hit;

  assign acc = cs & ce;
  assign rd  = acc & rw;
  assign wr  = acc & ~rw;

  assign ram_sel = ~rs;
  assign io_sel  = rs & ~addr[RB_A2];
  assign tmr_sel = rs & addr[RB_A2] & ~addr[RB_A0];
  assign flg_sel = rs & addr[RB_A2] & addr[RB_A0];

  assign ram_wr = wr & ram_sel;
  assign io_wr  = wr & io_sel;
  assign edg_wr = wr & rs & addr[RB_A2] & ~addr[RB_A4];
  assign tmr_ld = wr & rs & addr[RB_A2] & addr[RB_A4];
  assign tmr_rd = rd & tmr_sel;
  assign flg_rd = rd & flg_sel;

  assign pa_pin = (paIn & ~paDdr) | (paOut & paDdr);
  assign pb_pin = (pbIn & ~pbDdr) | (pbOut & pbDdr);

  // sh[SYNC_STAGES] is the previous value of the last synchroniser stage
  assign edge_hit = pol ? (sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES])
                        : (~sh[SYNC_STAGES-1] & sh[SYNC_STAGES]);

  riot_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .load     (tmr_ld),
    .load_val (dataIn),
    .load_ps  (ps_e'(addr[1:0])),
    .rd_clr   (tmr_rd),
    .count    (tcount),
    .tflag    (tflag)
  );

  always_ff @(posedge clk) begin
    if (ram_wr)
      mem[addr] <= dataIn;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      ram_sel: rdata = mem[addr];
      io_sel: begin
        unique case (addr[1:0])
          OFS_DRA:  rdata = 8'(pa_pin);
          OFS_DDRA: rdata = 8'(paDdr);
          OFS_DRB:  rdata = 8'(pb_pin);
          OFS_DDRB: rdata = 8'(pbDdr);
        endcase
      end
      tmr_sel: rdata = 8'(tcount);
      flg_sel: begin
        rdata[FLG_T] = tflag;
        rdata[FLG_P] = pflag;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut <= '0;
      paOut   <= '0;
      paDdr   <= '0;
      pbOut   <= '0;
      pbDdr   <= '0;
      tie     <= 1'b0;
      pie     <= 1'b0;
      pol     <= 1'b0;
      pflag   <= 1'b0;
      sh      <= '0;
      irq     <= 1'b0;
    end else begin
      sh  <= {sh[SYNC_STAGES-1:0], paIn[EDGE_BIT]};
      irq <= (tflag & tie) | (pflag & pie);
      if (rd)
        dataOut <= rdata;
      if (io_wr) begin
        unique case (addr[1:0])
          OFS_DRA:  paOut <= PORT_W'(dataIn);
          OFS_DDRA: paDdr <= PORT_W'(dataIn);
          OFS_DRB:  pbOut <= PORT_W'(dataIn);
          OFS_DDRB: pbDdr <= PORT_W'(dataIn);
        endcase
      end
      if (edg_wr) begin
        pie <= addr[RB_A1];
        pol <= addr[RB_A0];
      end
      if (tmr_ld | tmr_rd)
        tie <= addr[RB_A3];
      if (edge_hit)
        pflag <= 1'b1;
      else if (flg_rd)
        pflag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riot_gen.sv
// tb_riot_gen: table vectors, hand sequences and random traffic checked
// against an arithmetic model of the RIOT register/timer behaviour.
module tb_riot_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce, cs, rw, rs;
  logic [6:0] addr;
  logic [7:0] dataIn, dataOut;
  logic [7:0] paIn, paOut, paDdr, pbIn, pbOut, pbDdr;
  logic       irq;

  int checks = 0;
  int failures = 0;

  riot_gen dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .cs      (cs),
    .rw      (rw),
    .rs      (rs),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .paIn    (paIn),
    .paOut   (paOut),
    .paDdr   (paDdr),
    .pbIn    (pbIn),
    .pbOut   (pbOut),
    .pbDdr   (pbDdr),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // model state
  logic [7:0] ram_m [128];
  logic [7:0] dra_m, ddra_m, drb_m, ddrb_m, do_m;
  int  tv, tp, tn;
  bit  tf_m, pf_m, tie_m, pie_m, pol_m;
  bit  chk_irq;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ps_div(input logic [1:0] c);
    int r;
    r = 1;
    case (c)
      2'd0: r = 1;
      2'd1: r = 8;
      2'd2: r = 64;
      default: r = 1024;
    endcase
    return r;
  endfunction

  // value after n ce ticks since load: V - n/P, then free-running mod 256
  function automatic logic [7:0] tval();
    int lim;
    lim = (tv + 1) * tp;
    if (tn < lim)
      return 8'(tv - tn / tp);
    return 8'(255 - ((tn - lim) % 256));
  endfunction

  function automatic bit underflow(input int n);
    int lim;
    lim = (tv + 1) * tp;
    return (n >= lim) && (((n - lim) % 256) == 0);
  endfunction

  task automatic model_reset();
    dra_m = 0; ddra_m = 0; drb_m = 0; ddrb_m = 0; do_m = 0;
    tv = 255; tp = 1024; tn = 0;
    tf_m = 0; pf_m = 0; tie_m = 0; pie_m = 0; pol_m = 0;
  endtask

  task automatic step(input bit c, input bit w, input bit r_s,
                      input logic [6:0] a, input logic [7:0] d,
                      input bit e);
    bit acc, ld, tr, fr, uf, irq_e;
    logic [7:0] pa_pin, pb_pin;
    cs = c; rw = w; rs = r_s; addr = a; dataIn = d; ce = e;
    acc = c && e;
    irq_e = (tf_m && tie_m) || (pf_m && pie_m);
    pa_pin = (paIn & ~ddra_m) | (dra_m & ddra_m);
    pb_pin = (pbIn & ~ddrb_m) | (drb_m & ddrb_m);
    if (acc && w) begin
      if (!r_s) do_m = ram_m[a];
      else if (!a[2]) begin
        case (a[1:0])
          2'd0: do_m = pa_pin;
          2'd1: do_m = ddra_m;
          2'd2: do_m = pb_pin;
          default: do_m = ddrb_m;
        endcase
      end
      else if (!a[0]) do_m = tval();
      else do_m = {tf_m, pf_m, 6'b0};
    end
    ld = acc && !w && r_s && a[2] && a[4];
    tr = acc && w && r_s && a[2] && !a[0];
    fr = acc && w && r_s && a[2] && a[0];
    uf = 0;
    if (acc && !w) begin
      if (!r_s) ram_m[a] = d;
      else if (!a[2]) begin
        case (a[1:0])
          2'd0: dra_m = d;
          2'd1: ddra_m = d;
          2'd2: drb_m = d;
          default: ddrb_m = d;
        endcase
      end
      else if (!a[4]) begin pie_m = a[1]; pol_m = a[0]; end
      else begin
        tv = int'(d); tp = ps_div(a[1:0]); tn = 0;
        tie_m = a[3]; tf_m = 0;
      end
    end
    if (e && !ld) begin tn++; uf = underflow(tn); end
    if (tr) begin tf_m = 0; tie_m = a[3]; end
    if (fr) pf_m = 0;
    if (uf) tf_m = 1;
    @(negedge clk);
    check("dataOut", dataOut, do_m);
    if (chk_irq) check("irq", irq, irq_e);
    check("paOut", paOut, dra_m);
    check("paDdr", paDdr, ddra_m);
    check("pbOut", pbOut, drb_m);
    check("pbDdr", pbDdr, ddrb_m);
  endtask

  task automatic idle();
    step(0, 1, 0, 7'h00, 8'h00, 1);
  endtask

  typedef struct {
    bit         w;
    bit         r_s;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] pa;
    logic [7:0] pb;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    reset = 0; ce = 0; cs = 0; rw = 1; rs = 0; addr = 0; dataIn = 0;
    paIn = 0; pbIn = 0; chk_irq = 1;
    model_reset();
    for (int i = 0; i < 128; i++) ram_m[i] = 8'h00;

    #1;
    check("rst_dataOut", dataOut, 8'h00);
    check("rst_paOut", paOut, 8'h00);
    check("rst_paDdr", paDdr, 8'h00);
    check("rst_pbOut", pbOut, 8'h00);
    check("rst_pbDdr", pbDdr, 8'h00);
    check("rst_irq", irq, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;

    // fill RAM so every later random read has a known value
    for (int i = 0; i < 128; i++) step(1, 0, 0, 7'(i), 8'($urandom), 1);

    // w rs a d pa pb chk exp
    tbl[0]  = '{0, 1, 7'h01, 8'hF0, 8'h3C, 8'h00, 0, 8'h00};
    tbl[1]  = '{0, 1, 7'h00, 8'hA5, 8'h3C, 8'h00, 0, 8'h00};
    tbl[2]  = '{1, 1, 7'h00, 8'h00, 8'h3C, 8'h00, 1, 8'hAC};
    tbl[3]  = '{1, 1, 7'h01, 8'h00, 8'h3C, 8'h00, 1, 8'hF0};
    tbl[4]  = '{0, 1, 7'h03, 8'h0F, 8'h3C, 8'h99, 0, 8'h00};
    tbl[5]  = '{0, 1, 7'h02, 8'h66, 8'h3C, 8'h99, 0, 8'h00};
    tbl[6]  = '{1, 1, 7'h02, 8'h00, 8'h3C, 8'h99, 1, 8'h96};
    tbl[7]  = '{1, 1, 7'h03, 8'h00, 8'h3C, 8'h99, 1, 8'h0F};
    tbl[8]  = '{0, 0, 7'h7F, 8'h5A, 8'h3C, 8'h99, 0, 8'h00};
    tbl[9]  = '{0, 0, 7'h00, 8'h11, 8'h3C, 8'h99, 0, 8'h00};
    tbl[10] = '{1, 0, 7'h7F, 8'h00, 8'h3C, 8'h99, 1, 8'h5A};
    tbl[11] = '{1, 0, 7'h00, 8'h00, 8'h3C, 8'h99, 1, 8'h11};
    for (int i = 0; i < 12; i++) begin
      paIn = tbl[i].pa;
      pbIn = tbl[i].pb;
      step(1, tbl[i].w, tbl[i].r_s, tbl[i].a, tbl[i].d, 1);
      if (tbl[i].chk) check($sformatf("tbl%0d", i), dataOut, tbl[i].exp);
    end
    check("tbl_paDdr", paDdr, 8'hF0);
    check("tbl_paOut", paOut, 8'hA5);

    // timer /8, TIE=1, load 5
    step(1, 0, 1, 7'h1D, 8'h05, 1);
    repeat (8) idle();
    step(1, 1, 1, 7'h0C, 8'h00, 1);
    check("tmr_div8", dataOut, 8'h04);
    repeat (38) idle();
    check("tmr_pre_uf", irq, 1'b0);
    idle();
    check("tmr_uf_lat", irq, 1'b0);
    idle();
    check("tmr_uf_irq", irq, 1'b1);
    step(1, 1, 1, 7'h04, 8'h00, 1);
    check("tmr_fast0", dataOut, 8'hFE);
    check("irq_hold", irq, 1'b1);
    step(1, 1, 1, 7'h04, 8'h00, 1);
    check("tmr_fast1", dataOut, 8'hFD);
    check("irq_drop", irq, 1'b0);
    step(1, 1, 1, 7'h04, 8'h00, 1);
    check("tmr_fast2", dataOut, 8'hFC);
    step(1, 0, 1, 7'h1F, 8'h02, 1);
    repeat (5) idle();
    step(1, 1, 1, 7'h04, 8'h00, 1);
    check("tmr_div1024", dataOut, 8'h02);

    // cs held without ce: no clear, no write
    step(1, 0, 1, 7'h1C, 8'h00, 1);
    idle();
    idle();
    repeat (4) step(1, 1, 1, 7'h0C, 8'h00, 0);
    check("hold_noclr", irq, 1'b1);
    repeat (4) step(1, 0, 0, 7'h7F, 8'hFF, 0);
    step(1, 1, 0, 7'h7F, 8'h00, 1);
    check("hold_nowr", dataOut, 8'h5A);

    // edge detect, rising, PIE=1
    step(1, 0, 1, 7'h17, 8'hFF, 1);
    step(1, 1, 1, 7'h05, 8'h00, 1);
    step(1, 0, 1, 7'h07, 8'h00, 1);
    chk_irq = 0;
    paIn = 8'h80;
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("edge_wait%0d", i), irq, 1'b0);
    end
    idle();
    check("edge_irq", irq, 1'b1);
    pf_m = 1;
    chk_irq = 1;
    step(1, 1, 1, 7'h05, 8'h00, 1);
    check("pflag_rd", dataOut, 8'h40);
    idle();
    check("pflag_irq_drop", irq, 1'b0);
    step(1, 1, 1, 7'h05, 8'h00, 1);
    check("pflag_clr", dataOut, 8'h00);
    paIn = 8'h00;
    repeat (5) idle();
    step(1, 1, 1, 7'h05, 8'h00, 1);
    check("no_fall_edge", dataOut, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit c, w, r_s, e;
      logic [6:0] a;
      logic [7:0] d;
      c = ($urandom_range(0, 9) < 7);
      w = 1'($urandom_range(0, 1));
      r_s = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      a = 7'($urandom);
      d = 8'($urandom);
      if (r_s && !w && a[2] && a[4]) d = 8'($urandom_range(0, 6));
      paIn = 8'($urandom) & 8'h7F;
      pbIn = 8'($urandom);
      step(c, w, r_s, a, d, e);
    end

    // reset mid-count with TFLAG set
    step(1, 0, 1, 7'h00, 8'h3C, 1);
    step(1, 0, 0, 7'h7F, 8'h5A, 1);
    step(1, 0, 1, 7'h1C, 8'h00, 1);
    idle();
    idle();
    check("pre_rst_irq", irq, 1'b1);
    check("pre_rst_paOut", paOut, 8'h3C);
    reset = 0;
    #1;
    check("rst_mid_irq", irq, 1'b0);
    check("rst_mid_paOut", paOut, 8'h00);
    check("rst_mid_dataOut", dataOut, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1;
    step(1, 1, 1, 7'h04, 8'h00, 1);
    check("rst_timer", dataOut, 8'hFF);
    step(1, 1, 0, 7'h7F, 8'h00, 1);
    check("rst_ram_kept", dataOut, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
